// File: rtl/bird_renderer.sv
`timescale 1ns/1ps
// bird_renderer
// Draws a flappy-bird style scene (sky, ground, one square bird) into the
// VGA pixel stream and runs the bird physics once per frame.
//
// Ports:
//   clk, n_rst        pixel clock, asynchronous active-low reset
//   x_val, y_val      pixel coordinates from the VGA counter
//   hsync_in/vsync_in syncs, one cycle behind x_val/y_val
//   flap              flap button level, synchronous to clk
//   hsync, vsync      syncs delayed to line up with rgb
//   rgb               {R,G,B} 4 bits each, 2 cycles after x_val
//   game_state        FSM state: 0=IDLE, 1=PLAY, 2=DEAD (debug visible)
//
// Handshake: no valid/ready here; the pixel stream is free-running and
// every clock carries one pixel, so each stage simply registers every cycle.
module bird_renderer #(
  parameter int BIRD_X    = 160,
  parameter int BIRD_SIZE = 16,
  parameter int GROUND_Y  = 464,
  parameter int START_Y   = 232,
  parameter int FLAP_VEL  = -6,
  parameter int VMAX      = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [9:0]  x_val,
  input  logic [9:0]  y_val,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        flap,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic [1:0]  game_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  localparam logic [9:0]         START_Y_C = 10'(START_Y);
  localparam logic signed [7:0]  FLAP_V    = 8'(FLAP_VEL);
  localparam logic signed [8:0]  VMAX_C    = 9'(VMAX);
  localparam logic signed [11:0] Y_FLOOR   = 12'(GROUND_Y - BIRD_SIZE);
  localparam logic [10:0]        BX_LO     = 11'(BIRD_X);
  localparam logic [10:0]        BX_HI     = 11'(BIRD_X + BIRD_SIZE);
  localparam logic [10:0]        GND_C     = 11'(GROUND_Y);
  localparam logic [10:0]        SIZE_C    = 11'(BIRD_SIZE);

  localparam logic [11:0] C_BLACK = 12'h000;
  localparam logic [11:0] C_BIRD  = 12'hFF0;
  localparam logic [11:0] C_DEAD  = 12'hF00;
  localparam logic [11:0] C_GND   = 12'h852;
  localparam logic [11:0] C_SKY   = 12'h5BF;

  logic [1:0]        state_q, state_d;
  logic [9:0]        bird_y_q, bird_y_d;
  logic signed [7:0] bird_vel_q, bird_vel_d;
  logic              vsync_in_q, flap_q;
  logic              flap_pending_q, flap_pending_d;
  logic              active_q, bird_q, ground_q;
  logic              hsync_q, vsync_q;
  logic [11:0]       rgb_q, rgb_d;

  // ---------------- stage 1: region compares ----------------
  logic [10:0] x11, y11, bird_bot;
  logic        in_active, in_bird, in_ground;

  always_comb begin
    x11       = {1'b0, x_val};
    y11       = {1'b0, y_val};
    bird_bot  = {1'b0, bird_y_q} + SIZE_C;
    in_active = (x_val <= 10'd639) && (y_val <= 10'd479);
    in_bird   = (x11 >= BX_LO) && (x11 < BX_HI) &&
                (y11 >= {1'b0, bird_y_q}) && (y11 < bird_bot);
    in_ground = (y11 >= GND_C);
  end

  // ---------------- stage 2: colour select ----------------
  always_comb begin
    rgb_d = C_SKY;
    if (!active_q)     rgb_d = C_BLACK;
    else if (bird_q)   rgb_d = (state_q == ST_DEAD) ? C_DEAD : C_BIRD;
    else if (ground_q) rgb_d = C_GND;
  end

  // ---------------- frame tick / flap edge ----------------
  logic tick, flap_edge, flap_hit;
  assign tick      = vsync_in & ~vsync_in_q;
  assign flap_edge = flap & ~flap_q;
  // A flap edge landing on the tick cycle must still count for that tick.
  assign flap_hit  = flap_pending_q | flap_edge;

  always_comb begin
    flap_pending_d = tick ? 1'b0 : (flap_pending_q | flap_edge);
  end

  // ---------------- physics ----------------
  logic signed [11:0] ny;
  logic signed [8:0]  vel_inc;
  logic signed [7:0]  vel_fall;

  always_comb begin
    ny       = $signed({2'b00, bird_y_q}) + $signed({{4{bird_vel_q[7]}}, bird_vel_q});
    vel_inc  = $signed({bird_vel_q[7], bird_vel_q}) + 9'sd1;
    vel_fall = (vel_inc > VMAX_C) ? VMAX_C[7:0] : vel_inc[7:0];
  end

  always_comb begin
    state_d    = state_q;
    bird_y_d   = bird_y_q;
    bird_vel_d = bird_vel_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          bird_y_d   = START_Y_C;
          bird_vel_d = 8'sd0;
          if (flap_hit) begin
            state_d    = ST_PLAY;
            bird_vel_d = FLAP_V;
          end
        end
        ST_PLAY: begin
          // Position moves by the old velocity; clamps override the new one.
          bird_vel_d = flap_hit ? FLAP_V : vel_fall;
          if (ny[11]) begin
            bird_y_d   = 10'd0;
            bird_vel_d = 8'sd0;
          end else if (ny >= Y_FLOOR) begin
            bird_y_d   = Y_FLOOR[9:0];
            bird_vel_d = 8'sd0;
            state_d    = ST_DEAD;
          end else begin
            bird_y_d = ny[9:0];
          end
        end
        ST_DEAD: begin
          if (flap_hit) begin
            state_d    = ST_IDLE;
            bird_y_d   = START_Y_C;
            bird_vel_d = 8'sd0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          bird_y_d   = START_Y_C;
          bird_vel_d = 8'sd0;
        end
      endcase
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= ST_IDLE;
      bird_y_q       <= START_Y_C;
      bird_vel_q     <= 8'sd0;
      vsync_in_q     <= 1'b0;
      flap_q         <= 1'b0;
      flap_pending_q <= 1'b0;
      active_q       <= 1'b0;
      bird_q         <= 1'b0;
      ground_q       <= 1'b0;
      rgb_q          <= 12'h000;
      hsync_q        <= 1'b0;
      vsync_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      bird_y_q       <= bird_y_d;
      bird_vel_q     <= bird_vel_d;
      vsync_in_q     <= vsync_in;
      flap_q         <= flap;
      flap_pending_q <= flap_pending_d;
      active_q       <= in_active;
      bird_q         <= in_bird;
      ground_q       <= in_ground;
      rgb_q          <= rgb_d;
      hsync_q        <= hsync_in;
      vsync_q        <= vsync_in;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign rgb        = rgb_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_bird_renderer.sv
`timescale 1ns/1ps
module tb_bird_renderer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [9:0]  x_val = 10'd0;
  logic [9:0]  y_val = 10'd0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        flap = 1'b0;
  logic        hsync, vsync;
  logic [11:0] rgb;
  logic [1:0]  game_state;

  always #20 clk = ~clk;

  bird_renderer dut (
    .clk(clk), .n_rst(n_rst), .x_val(x_val), .y_val(y_val),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .flap(flap),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .game_state(game_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected bird positions along the scripted fall.
  logic [9:0] exp_q[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit with_flap);
    if (with_flap) begin
      flap = 1'b1; step(); flap = 1'b0; step();
    end
    vsync_in = 1'b1; step();
    vsync_in = 1'b0; step();
  endtask

  task automatic pix(input string tag, input int x, input int y, input int exp);
    x_val = 10'(x);
    y_val = 10'(y);
    step();
    step();
    check_eq(tag, int'(rgb), exp);
  endtask

  task automatic phys(input string tag, input int st, input int y, input int v);
    check_eq({tag, "_state"}, int'(game_state), st);
    check_eq({tag, "_y"}, int'(dut.bird_y_q), y);
    check_eq({tag, "_vel"}, int'($signed(dut.bird_vel_q)), v);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset state
    #50;
    check_eq("rst_rgb", int'(rgb), 0);
    check_eq("rst_hsync", int'(hsync), 0);
    check_eq("rst_vsync", int'(vsync), 0);
    phys("rst", 0, 232, 0);
    @(negedge clk);
    n_rst = 1'b1;
    step();

    // Alignment: bird pixel in IDLE, hsync one cycle delayed
    x_val = 10'd160; y_val = 10'd232; hsync_in = 1'b1;
    step();
    check_eq("align_hsync_hi", int'(hsync), 1);
    hsync_in = 1'b0;
    step();
    check_eq("align_rgb", int'(rgb), 'hFF0);
    check_eq("align_hsync_lo", int'(hsync), 0);

    // Region and boundary pixels
    pix("blank_x700", 700, 100, 'h000);
    pix("blank_y480", 10, 480, 'h000);
    pix("ground_470", 10, 470, 'h852);
    pix("ground_corner", 639, 479, 'h852);
    pix("ground_464", 10, 464, 'h852);
    pix("sky_463", 10, 463, 'h5BF);
    pix("sky_100", 10, 100, 'h5BF);
    pix("bird_br", 175, 247, 'hFF0);
    pix("bird_right_out", 176, 247, 'h5BF);
    pix("bird_below_out", 175, 248, 'h5BF);
    pix("bird_above_out", 160, 231, 'h5BF);

    // vsync tick without flap keeps IDLE; vsync output follows input
    vsync_in = 1'b1; step();
    check_eq("vsync_hi", int'(vsync), 1);
    vsync_in = 1'b0; step();
    phys("idle_noflap", 0, 232, 0);

    // Start: flap then tick
    tick(1'b1);
    phys("start_t0", 1, 232, -6);
    tick(1'b0);
    phys("start_t1", 1, 226, -5);

    // Fall: hand-computed trajectory for ticks T2..T14, then +8 per tick
    exp_q = '{221, 217, 214, 212, 211, 211, 212, 214, 217, 221, 226, 232, 239};
    for (int t = 2; t <= 14; t++) begin
      tick(1'b0);
      check_eq($sformatf("fall_t%0d_y", t), int'(dut.bird_y_q), int'(exp_q.pop_front()));
    end
    check_eq("fall_vmax", int'($signed(dut.bird_vel_q)), 8);
    tick(1'b0);
    phys("fall_t15_sat", 1, 247, 8);
    for (int t = 16; t <= 40; t++) tick(1'b0);
    phys("fall_t40", 1, 447, 8);
    tick(1'b0);
    phys("fall_dead", 2, 448, 0);

    pix("dead_top", 160, 448, 'hF00);
    pix("dead_bot", 175, 463, 'hF00);
    pix("dead_ground", 160, 464, 'h852);
    pix("dead_side", 176, 450, 'h5BF);

    // DEAD frozen without flap
    tick(1'b0);
    phys("dead_frozen", 2, 448, 0);

    // Flap edge coincident with tick in DEAD -> IDLE
    flap = 1'b1; vsync_in = 1'b1; step();
    flap = 1'b0; vsync_in = 1'b0; step();
    phys("coinc_idle", 0, 232, 0);

    // Ceiling: steer bird to y=3, vel=-6 then tick without flap
    tick(1'b1);
    phys("ceil_start", 1, 232, -6);
    for (int p = 0; p < 5; p++) begin
      tick(1'b0);
      tick(1'b1);
    end
    phys("ceil_pairs", 1, 177, -6);
    for (int m = 0; m < 29; m++) tick(1'b1);
    phys("ceil_pre", 1, 3, -6);
    tick(1'b0);
    phys("ceil_clamp", 1, 0, 0);

    // Reset pulse during PLAY
    x_val = 10'd10; y_val = 10'd100; hsync_in = 1'b1;
    step(); step();
    check_eq("pre_rst_rgb", int'(rgb), 'h5BF);
    #5;
    n_rst = 1'b0;
    #1;
    check_eq("mid_rst_state", int'(game_state), 0);
    check_eq("mid_rst_rgb", int'(rgb), 0);
    check_eq("mid_rst_hsync", int'(hsync), 0);
    check_eq("mid_rst_y", int'(dut.bird_y_q), 232);
    step();
    check_eq("held_rst_rgb", int'(rgb), 0);
    hsync_in = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    step();
    tick(1'b0);
    phys("post_rst_tick", 0, 232, 0);
    pix("post_rst_bird", 160, 232, 'hFF0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bird_renderer.md
BIRD_RENDERER -- requirements
Module: bird_renderer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- BIRD_X, 160, left column of the bird sprite
- BIRD_SIZE, 16, bird square edge in pixels
- GROUND_Y, 464, first ground row
- START_Y, 232, bird top row after reset or restart
- FLAP_VEL, -6, velocity loaded on a flap (signed)
- VMAX, 8, terminal fall velocity
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, 25 MHz pixel clock
- n_rst, in, 1, active-low reset
- x_val, in, 10, current pixel column from the VGA counter
- y_val, in, 10, current pixel row from the VGA counter
- hsync_in, in, 1, active-high hsync, one cycle behind x_val
- vsync_in, in, 1, active-high vsync, one cycle behind y_val
- flap, in, 1, synchronous flap button level
- hsync, out, 1, hsync aligned to rgb
- vsync, out, 1, vsync aligned to rgb
- rgb, out, 12, pixel colour {R[3:0], G[3:0], B[3:0]}
- game_state, out, 2, 0=IDLE, 1=PLAY, 2=DEAD
REQ-003 The block SHALL use one clock, clk, with asynchronous active-low reset n_rst.

Function
REQ-004 Pixel pipeline SHALL be 2 stages: stage 1 registers the region compares for x_val/y_val, and stage 2 registers the colour, so rgb for (x,y) appears 2 cycles after x_val=x.
REQ-005 hsync and vsync SHALL be hsync_in and vsync_in delayed by exactly 1 register, so they align with rgb.
REQ-006 Colour priority:
- active area is x<=639 and y<=479; outside it rgb=12'h000
- bird region: BIRD_X<=x<BIRD_X+BIRD_SIZE and bird_y<=y<bird_y+BIRD_SIZE; colour 12'hFF0, or 12'hF00 in DEAD
- ground region: y>=GROUND_Y; colour 12'h852
- otherwise sky, 12'h5BF
REQ-007 Frame tick SHALL be the vsync_in rising edge, detected against a registered copy of vsync_in; physics updates only on the tick cycle.
REQ-008 Flap edge: a rising edge on flap (0->1 against a registered copy) SHALL set flap_pending; flap_pending clears on every tick. An edge coincident with a tick counts for that tick.
REQ-009 State bird_y is unsigned 10-bit; bird_vel is signed 8-bit. Sums SHALL be computed in signed 11-bit or wider.
REQ-010 FSM IDLE:
- bird_y=START_Y, bird_vel=0
- tick with flap_pending -> PLAY, bird_vel<=FLAP_VEL, bird_y unchanged
REQ-011 FSM PLAY on tick:
- ny=bird_y+bird_vel, using the old velocity
- bird_vel<=FLAP_VEL if flap_pending, else min(bird_vel+1, VMAX)
REQ-012 PLAY clamps:
- ny<0: bird_y<=0, bird_vel<=0
- ny>=GROUND_Y-BIRD_SIZE (448): bird_y<=448, bird_vel<=0, state<=DEAD
- otherwise bird_y<=ny
REQ-013 FSM DEAD: bird frozen; tick with flap_pending -> IDLE, bird_y<=START_Y, bird_vel<=0.
REQ-014 Physics registers SHALL change only on ticks, which fall in vertical blank, so the bird position is constant across one visible frame.
REQ-015 game_state SHALL reflect the registered FSM state with no added latency.

Reset
REQ-016 When n_rst=0, the block SHALL immediately force:
- state=IDLE, bird_y=START_Y, bird_vel=0
- flap_pending=0, edge-detect registers=0
- pipeline registers, rgb, hsync, vsync all 0
REQ-017 Reset asserted mid-frame or mid-PLAY SHALL abandon all state; after release, the first tick evaluates IDLE rules.

Verification
REQ-018 Align:
- stimulus: x_val=BIRD_X, y_val=START_Y in IDLE
- response: rgb=12'hFF0 two cycles later; the same cycle's hsync_in appears on hsync one cycle later
REQ-019 Blank and ground:
- x_val=700 -> rgb=000
- y_val=470, x_val=10 -> rgb=852
- y_val=100, x_val=10 -> rgb=5BF
REQ-020 Start:
- stimulus: flap pulse in IDLE, then vsync_in rising
- response: state=PLAY, bird_vel=-6, bird_y=232
- next tick: bird_y=226, bird_vel=-5
REQ-021 Fall:
- stimulus: PLAY with no flaps
- response: bird_vel saturates at 8; bird_y reaches 448; state=DEAD; bird renders 12'hF00
REQ-022 Ceiling:
- stimulus: bird_y=3, bird_vel=-6 at a tick, no flap
- response: bird_y=0, bird_vel=0
REQ-023 Coincidence and reset:
- flap edge on the same cycle as the tick in DEAD -> IDLE, bird_y=232
- n_rst pulse during PLAY -> state=0 and rgb=000 while reset is asserted
